// File: rtl/arc4_decrypt.sv
// ARC4 decryption engine: init, key scheduling and keystream generation over an
// internal 256-byte state array, reading a length-prefixed ciphertext ROM and writing plaintext RAM.
module arc4_decrypt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  ct_addr,
  input  logic [7:0]  ct_rddata,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  pt_wrdata,
  output logic        pt_wren
);

  typedef enum logic [3:0] {
    ST_RESET = 4'd1,
    ST_START = 4'd2,
    ST_INIT  = 4'd3,
    ST_KSA   = 4'd4,
    ST_PRGA  = 4'd5,
    ST_DONE  = 4'd6,
    ST_PAUSE = 4'd7,
    ST_KSA2  = 4'd8,
    ST_PRGA2 = 4'd9
  } state_t;

  state_t      current_state;
  logic [7:0]  s_q [0:255];
  logic [7:0]  i_q, j_q, k_q, len_q;
  logic [23:0] key_q;
  logic [1:0]  km_q;

  logic [7:0]  s_i_d, s_j_d, i_inc_d, s_inc_d, kbyte_d, ks_j_d, prga_j_d, t_d, pad_d;
  logic        unused_pt_rddata;

  assign unused_pt_rddata = ^pt_rddata;

  assign s_i_d    = s_q[i_q];
  assign s_j_d    = s_q[j_q];
  assign i_inc_d  = i_q + 8'd1;
  assign s_inc_d  = s_q[i_inc_d];
  assign kbyte_d  = (km_q == 2'd0) ? key_q[23:16] :
                    (km_q == 2'd1) ? key_q[15:8]  : key_q[7:0];
  assign ks_j_d   = j_q + s_i_d + kbyte_d;
  assign prga_j_d = j_q + s_inc_d;
  // Pad is taken from the array as it will look after this cycle's swap.
  assign t_d      = s_i_d + s_j_d;
  assign pad_d    = (t_d == i_q) ? s_j_d :
                    (t_d == j_q) ? s_i_d : s_q[t_d];

  always_ff @(posedge clk) begin
    if (current_state == ST_INIT) begin
      s_q[i_q] <= i_q;
    end else if (current_state == ST_KSA2 || current_state == ST_PRGA2) begin
      s_q[i_q] <= s_j_d;
      s_q[j_q] <= s_i_d;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      current_state <= ST_RESET;
      rdy       <= 1'b0;
      pt_wren   <= 1'b0;
      ct_addr   <= 8'd0;
      pt_addr   <= 8'd0;
      pt_wrdata <= 8'd0;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      k_q       <= 8'd0;
      len_q     <= 8'd0;
      key_q     <= 24'd0;
      km_q      <= 2'd0;
    end else begin
      pt_wren <= 1'b0;
      case (current_state)
        ST_RESET: begin
          rdy           <= 1'b1;
          current_state <= ST_START;
        end
        ST_START, ST_DONE: begin
          if (en) begin
            key_q         <= key;
            rdy           <= 1'b0;
            i_q           <= 8'd0;
            ct_addr       <= 8'd0;
            current_state <= ST_INIT;
          end
        end
        ST_INIT: begin
          i_q <= i_inc_d;
          if (i_q == 8'hFF) begin
            j_q           <= 8'd0;
            km_q          <= 2'd0;
            current_state <= ST_KSA;
          end
        end
        ST_KSA: begin
          j_q           <= ks_j_d;
          current_state <= ST_KSA2;
        end
        ST_KSA2: begin
          i_q  <= i_inc_d;
          km_q <= (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
          if (i_q == 8'hFF) begin
            j_q           <= 8'd0;
            k_q           <= 8'd0;
            ct_addr       <= 8'd0;
            current_state <= ST_PRGA;
          end else begin
            current_state <= ST_KSA;
          end
        end
        ST_PRGA: begin
          // ct[0] has been on the ROM output since the start of the run.
          if (k_q == 8'd0) begin
            len_q         <= ct_rddata;
            pt_addr       <= 8'd0;
            pt_wrdata     <= ct_rddata;
            pt_wren       <= 1'b1;
            current_state <= ST_PAUSE;
          end else begin
            i_q           <= i_inc_d;
            j_q           <= prga_j_d;
            current_state <= ST_PRGA2;
          end
        end
        ST_PRGA2: begin
          pt_addr       <= k_q;
          pt_wrdata     <= ct_rddata ^ pad_d;
          pt_wren       <= 1'b1;
          current_state <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (k_q == len_q) begin
            rdy           <= 1'b1;
            current_state <= ST_DONE;
          end else begin
            k_q           <= k_q + 8'd1;
            ct_addr       <= k_q + 8'd1;
            current_state <= ST_PRGA;
          end
        end
        default: begin
          rdy           <= 1'b0;
          current_state <= ST_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_decrypt.sv
// Directed bench for arc4_decrypt: ROM/RAM models, a reference RC4 model that
// feeds an expected-write queue, and state/phase checks at the step boundaries.
module tb_arc4_decrypt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  ct_addr, ct_rddata, pt_addr, pt_rddata, pt_wrdata;
  logic        pt_wren;

  logic [7:0]  rom [0:255];
  logic [7:0]  ram [0:255];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          n_writes = 0;

  always #5 clk = ~clk;

  arc4_decrypt dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  always @(posedge clk) begin
    ct_rddata <= rom[ct_addr];
    pt_rddata <= ram[pt_addr];
    if (pt_wren === 1'b1) ram[pt_addr] <= pt_wrdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] st();
    return dut.current_state;
  endfunction

  // Scoreboard: every write must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (pt_wren === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) chk("unexpected_write", {16'd0, pt_addr, pt_wrdata}, 32'h0001_0000);
      else                   chk("pt_write", {16'd0, pt_addr, pt_wrdata}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [23:0] kk);
    int s [256];
    int i, j, t, len;
    logic [7:0] kb [3];
    kb[0] = kk[23:16]; kb[1] = kk[15:8]; kb[2] = kk[7:0];
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + int'(kb[n % 3])) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = int'(rom[0]);
    exp_q.push_back({8'd0, rom[0]});
    i = 0; j = 0;
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[(s[i] + s[j]) % 256];
      exp_q.push_back({k[7:0], rom[k] ^ t[7:0]});
    end
  endtask

  task automatic start_run(input logic [23:0] kk, input bit push);
    if (push) model_push(kk);
    key = kk;
    en  = 1'b1;
    tick(1);
    en  = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int max);
    int n = 0;
    while (st() != s && n < max) begin
      tick(1);
      n++;
    end
    chk(tag, {28'd0, st()}, {28'd0, s});
  endtask

  task automatic load_vector();
    logic [7:0] v [10];
    v = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int n = 0; n < 10; n++) rom[n] = v[n];
  endtask

  task automatic check_plaintext();
    logic [7:0] p [10];
    p = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int n = 0; n < 10; n++) chk("plaintext", {24'd0, ram[n]}, {24'd0, p[n]});
  endtask

  initial begin
    int w0;
    rst_n = 1'b1; en = 1'b0; key = 24'd0;
    for (int n = 0; n < 256; n++) begin rom[n] = 8'd0; ram[n] = 8'd0; end

    // Reset and release
    tick(2);
    chk("reset_state", {28'd0, st()}, 32'd1);
    chk("reset_rdy", {31'd0, rdy}, 32'd0);
    chk("reset_wren", {31'd0, pt_wren}, 32'd0);
    @(negedge clk); rst_n = 1'b0;
    tick(1);
    chk("start_state", {28'd0, st()}, 32'd2);
    chk("start_rdy", {31'd0, rdy}, 32'd1);

    // Phase timing with an all-zero key and a 3-byte message
    rom[0] = 8'd3; rom[1] = 8'h11; rom[2] = 8'h22; rom[3] = 8'h33;
    start_run(24'h000000, 1'b1);
    chk("init_entry", {28'd0, st()}, 32'd3);
    chk("init_rdy", {31'd0, rdy}, 32'd0);
    tick(255);
    chk("init_last", {28'd0, st()}, 32'd3);
    tick(1);
    chk("ksa_entry", {28'd0, st()}, 32'd4);
    tick(1);
    chk("ksa2_entry", {28'd0, st()}, 32'd8);
    tick(511);
    chk("prga_entry", {28'd0, st()}, 32'd5);
    tick(1);
    chk("pause_len", {28'd0, st()}, 32'd7);
    chk("len_write", {23'd0, pt_wren, pt_addr}, {23'd0, 1'b1, 8'd0});
    wait_state("zero_key_done", 4'd6, 100);
    chk("zero_key_queue", exp_q.size(), 32'd0);

    // Known vector "Key" -> "Plaintext"
    load_vector();
    w0 = n_writes;
    start_run(24'h4B6579, 1'b1);
    wait_state("vec_done", 4'd6, 1000);
    chk("vec_rdy", {31'd0, rdy}, 32'd1);
    chk("vec_queue", exp_q.size(), 32'd0);
    chk("vec_writes", n_writes - w0, 32'd10);
    check_plaintext();
    tick(1);
    chk("done_wren", {31'd0, pt_wren}, 32'd0);

    // Empty message
    rom[0] = 8'd0;
    w0 = n_writes;
    start_run(24'h123456, 1'b1);
    wait_state("l0_prga", 4'd5, 1000);
    tick(1);
    chk("l0_pause", {28'd0, st()}, 32'd7);
    tick(1);
    chk("l0_done", {28'd0, st()}, 32'd6);
    chk("l0_rdy", {31'd0, rdy}, 32'd1);
    tick(2);
    chk("l0_writes", n_writes - w0, 32'd1);
    chk("l0_pt0", {24'd0, ram[0]}, 32'd0);

    // Abort during key scheduling, then a clean rerun
    load_vector();
    for (int n = 0; n < 10; n++) ram[n] = 8'hEE;
    w0 = n_writes;
    start_run(24'h4B6579, 1'b0);
    wait_state("abort_ksa", 4'd4, 400);
    rst_n = 1'b1;
    #1;
    chk("abort_state", {28'd0, st()}, 32'd1);
    chk("abort_wren", {31'd0, pt_wren}, 32'd0);
    tick(3);
    chk("abort_writes", n_writes - w0, 32'd0);
    @(negedge clk); rst_n = 1'b0;
    tick(1);
    chk("abort_start", {28'd0, st()}, 32'd2);
    start_run(24'h4B6579, 1'b1);
    wait_state("rerun_done", 4'd6, 1000);
    chk("rerun_queue", exp_q.size(), 32'd0);
    check_plaintext();

    // New key from done; en and key wiggle while busy
    rom[0] = 8'd20;
    for (int n = 1; n <= 20; n++) rom[n] = 8'($urandom_range(0, 255));
    w0 = n_writes;
    start_run(24'h01A2C3, 1'b1);
    en = 1'b1; key = 24'hFE5D3C;
    tick(3);
    chk("busy_ignore_en", {28'd0, st()}, 32'd3);
    en = 1'b0;
    wait_state("newkey_done", 4'd6, 2000);
    chk("newkey_queue", exp_q.size(), 32'd0);
    chk("newkey_writes", n_writes - w0, 32'd21);
    chk("newkey_len", {24'd0, ram[0]}, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/arc4_decrypt.md
Name: arc4_decrypt

Overview:
ARC4 (RC4) decryption engine with a single-byte-wide memory interface. It takes a 24-bit key and a length-prefixed ciphertext held in an external ROM. It runs init, key scheduling (KSA) and keystream generation (PRGA) over an internal 256-byte state array S. Each plaintext byte is written to an external plaintext RAM. It sits between the ciphertext ROM and plaintext RAM and is controlled by a rdy/en handshake.

Parameters:
none (message format, key width and S size are fixed)

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  reset; asynchronous, active-high (1 = reset asserted)
en  in  1  start request; sampled only while rdy=1
rdy  out  1  1 = idle and ready to accept en
key  in  24  key bytes; K0=key[23:16], K1=key[15:8], K2=key[7:0]
ct_addr  out  8  ciphertext ROM address
ct_rddata  in  8  ciphertext ROM data; synchronous read, valid the cycle after ct_addr is sampled
pt_addr  out  8  plaintext RAM address
pt_rddata  in  8  plaintext RAM read data; unused
pt_wrdata  out  8  plaintext RAM write data
pt_wren  out  1  plaintext RAM write enable; one-cycle pulse per byte

Behaviour:
- Message format: ct[0] = length L (0..255); ct[1..L] = ciphertext. Output: pt[0] = L, and pt[k] = ct[k] XOR pad_k for k = 1..L.
- State register current_state, 4 bits, readable hierarchically. Encodings: reset=1, start=2, initialize=3, keyschedule=4, randomnum=5, done=6, pause=7, keyschedule2=8, randomnum2=9.
- Reset (rst_n=1, asynchronous):
  - current_state=1.
  - rdy, pt_wren, ct_addr, pt_addr, pt_wrdata, i, j, k and L all go to 0.
  - Reset mid-operation aborts immediately; no further pt writes occur.
- reset -> start on the first clock edge after release.
- start: rdy=1. If en=1, latch key and go to initialize; otherwise stay. rdy=0 in every state except start and done.
- initialize:
  - One cycle per index: S[i]=i for i = 0..255 (exactly 256 cycles).
  - Then j=0, i=0, go to keyschedule.
- keyschedule: j = (j + S[i] + K[i mod 3]) mod 256 -> keyschedule2.
- keyschedule2:
  - Swap S[i] and S[j]; i++.
  - After i=255, go to randomnum with i=0, j=0, k=0; otherwise go to keyschedule.
  - KSA takes exactly 512 cycles.
- randomnum with k=0: ct_addr=0 -> pause.
- pause with k=0:
  - Latch L=ct_rddata.
  - Drive pt_addr=0, pt_wrdata=L, pt_wren=1.
  - If L=0 go to done; otherwise k=1, go to randomnum.
- randomnum with k>=1:
  - i=(i+1) mod 256, then j=(j+S[new i]) mod 256.
  - ct_addr=k -> randomnum2.
- randomnum2: swap S[i] and S[j]; latch ct_rddata -> pause.
- pause with k>=1:
  - pad = S[(S[i]+S[j]) mod 256], read from the post-swap array.
  - Drive pt_addr=k, pt_wrdata=latched ct XOR pad, pt_wren=1.
  - If k=L go to done; otherwise k++ and go to randomnum.
  - PRGA totals 2 + 3L cycles.
- done: rdy=1, outputs hold and pt_wren=0. en=1 latches a new key and goes to initialize (full rerun).
- Arithmetic: all index sums are mod 256, 8-bit wrap.
- en is ignored while busy. key changes after the latch have no effect.
- ct_addr and pt_addr hold their last values when not in use.
- S is internal with combinational read and a single-cycle two-location swap. Behaviour when i=j is a no-op.

Test Plan:
1. Reset: hold rst_n=1 -> current_state=1, rdy=0, pt_wren=0. Release -> current_state=2, rdy=1 after one edge.
2. Phase timing, key=24'h000000, en=1 in start: initialize for 256 cycles, then keyschedule/keyschedule2 alternating for 512 cycles, then randomnum. Check current_state at each boundary.
3. Known vector, key=24'h4B6579 ("Key"), ct = {09, BB F3 16 E8 D9 40 AF 0A D3}:
   - Writes pt[0]=09, then pt[1..9] = 50 6C 61 69 6E 74 65 78 74 ("Plaintext"), in address order, one pt_wren pulse each.
   - Then done with rdy=1.
4. L=0 (ct[0]=00): exactly one write, pt[0]=00; state done 2 cycles after PRGA entry.
5. Reset asserted during keyschedule: state immediately 1, no pt_wren. After release, a new en run with the step-3 vector produces correct output.
6. From done, en=1 with key changed -> reruns initialize; the output matches a software RC4 model for the new key.
